uart_pixel_cmd: RTL

UART_PIXEL_CMD -- requirements
Module: uart_pixel_cmd

---
 rtl/gfx_pkg.sv | 20 ++
 rtl/uart_pixel_cmd.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gfx_pkg.sv
// Shared opcode/response byte values and FSM state encoding for the UART pixel command parser.
package gfx_pkg;

    localparam logic [7:0] OP_PIXEL = 8'h50;
    localparam logic [7:0] OP_CLEAR = 8'h43;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_X,
        S_GET_Y,
        S_GET_C,
        S_WRITE,
        S_CLEAR,
        S_SEND,
        S_WAIT_TX
    } gfx_state_t;

endpackage

// File: rtl/uart_pixel_cmd.sv
// Parses pixel/clear command packets from a UART byte stream, drives frame-buffer writes
// and answers every complete packet with a single ACK/NAK byte.
module uart_pixel_cmd
    import gfx_pkg::*;
#(
    parameter int          H_RES   = 160,
    parameter int          V_RES   = 120,
    parameter int          COLOR_W = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000,
    localparam int         ADDR_W  = $clog2(H_RES * V_RES)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    output logic [7:0]         tx_data,
    output logic               tx_wr,
    input  logic               tx_done,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic               busy,
    output logic               overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    gfx_state_t         state_q;
    logic [7:0]         x_q;
    logic [7:0]         y_q;
    logic [COLOR_W-1:0] c_q;
    logic               clear_q;
    logic [7:0]         resp_q;
    logic [15:0]        tmo_q;
    logic [ADDR_W-1:0]  clr_q;
    logic               fb_we_q;
    logic [ADDR_W-1:0]  fb_addr_q;
    logic [COLOR_W-1:0] fb_wdata_q;
    logic               tx_wr_q;
    logic [7:0]         tx_data_q;
    logic               overrun_q;

    logic               in_range_d;
    logic [ADDR_W-1:0]  pix_addr_d;
    logic               rx_ignored_d;

    assign in_range_d   = (32'(x_q) < 32'(H_RES)) && (32'(y_q) < 32'(V_RES));
    assign pix_addr_d   = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);
    assign rx_ignored_d = rx_done && (state_q == S_WRITE || state_q == S_CLEAR ||
                                      state_q == S_SEND  || state_q == S_WAIT_TX);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            c_q        <= '0;
            clear_q    <= 1'b0;
            resp_q     <= '0;
            tmo_q      <= '0;
            clr_q      <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            tx_wr_q    <= 1'b0;
            tx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            fb_we_q   <= 1'b0;
            tx_wr_q   <= 1'b0;
            overrun_q <= rx_ignored_d;

            case (state_q)
                S_IDLE: begin
                    if (rx_done) begin
                        tmo_q <= '0;
                        if (rx_data == OP_PIXEL) begin
                            clear_q <= 1'b0;
                            state_q <= S_GET_X;
                        end else if (rx_data == OP_CLEAR) begin
                            clear_q <= 1'b1;
                            state_q <= S_GET_C;
                        end else begin
                            resp_q  <= RSP_NAK;
                            state_q <= S_SEND;
                        end
                    end
                end

                S_GET_X, S_GET_Y, S_GET_C: begin
                    if (rx_done) begin
                        tmo_q <= '0;
                        if (state_q == S_GET_X) begin
                            x_q     <= rx_data;
                            state_q <= S_GET_Y;
                        end else if (state_q == S_GET_Y) begin
                            y_q     <= rx_data;
                            state_q <= S_GET_C;
                        end else begin
                            c_q     <= rx_data[COLOR_W-1:0];
                            state_q <= clear_q ? S_CLEAR : S_WRITE;
                        end
                    end else if (tmo_q == TIMEOUT - 16'd1) begin
                        // Stalled packet is abandoned without any response.
                        tmo_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end

                S_WRITE: begin
                    if (in_range_d) begin
                        fb_we_q    <= 1'b1;
                        fb_addr_q  <= pix_addr_d;
                        fb_wdata_q <= c_q;
                        resp_q     <= RSP_ACK;
                    end else begin
                        resp_q <= RSP_NAK;
                    end
                    state_q <= S_SEND;
                end

                S_CLEAR: begin
                    fb_we_q    <= 1'b1;
                    fb_addr_q  <= clr_q;
                    fb_wdata_q <= c_q;
                    if (clr_q == LAST_ADDR) begin
                        clr_q   <= '0;
                        resp_q  <= RSP_ACK;
                        state_q <= S_SEND;
                    end else begin
                        clr_q <= clr_q + ADDR_W'(1);
                    end
                end

                S_SEND: begin
                    tx_wr_q   <= 1'b1;
                    tx_data_q <= resp_q;
                    state_q   <= S_WAIT_TX;
                end

                S_WAIT_TX: begin
                    if (tx_done) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;
    assign tx_wr    = tx_wr_q;
    assign tx_data  = tx_data_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != S_IDLE);

endmodule
